// File: rtl/ps2_host_tx_pkg.sv
// Shared definitions for the PS/2 host transmitter: command codes, device
// responses, FSM state encoding and the frame parity helper.
package ps2_host_tx_pkg;

  // Host-to-device command codes
  localparam logic [7:0] PS2_CMD_RESET  = 8'hFF;
  localparam logic [7:0] PS2_CMD_LEDS   = 8'hED;
  localparam logic [7:0] PS2_CMD_ENABLE = 8'hF4;

  // Device responses
  localparam logic [7:0] PS2_RSP_ACK    = 8'hFA;
  localparam logic [7:0] PS2_RSP_RESEND = 8'hFE;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StInhibit = 2'd1,
    StSend    = 2'd2,
    StWaitRel = 2'd3
  } state_e;

  // Odd parity bit for a command byte: set when the byte has an even number of ones
  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command handshake between a client and the PS/2 host transmitter.
interface ps2_host_tx_if;
  import ps2_host_tx_pkg::*;

  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       busy;
  logic       tx_done;
  logic       tx_err;

  // Client side: issues commands, watches completion
  modport master (
    output tx_valid,
    output tx_data,
    input  tx_ready,
    input  busy,
    input  tx_done,
    input  tx_err
  );

  // Transmitter side
  modport slave (
    input  tx_valid,
    input  tx_data,
    output tx_ready,
    output busy,
    output tx_done,
    output tx_err
  );

endinterface

// File: rtl/ps2_line_sync.sv
// Two-flop synchroniser for one raw PS/2 line plus a falling-edge strobe.
// Flops reset to 1 so an idle (pulled-up) line never looks like a fall.
module ps2_line_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic line,
  output logic sync,
  output logic fall
);

  logic [1:0] sync_q;
  logic       prev_q;

  // Synchroniser chain and one-cycle history for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[0], line};
      prev_q <= sync_q[1];
    end
  end

  assign sync = sync_q[1];
  assign fall = prev_q & ~sync_q[1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter. Inhibits the bus, sets up the start bit,
// then shifts data/parity/stop on device clock falls and samples the ack bit.
// Lines are only ever pulled low; the enclosing level builds the tristates.
module ps2_host_tx
  import ps2_host_tx_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = 12000,
  parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
  input  logic            clk,
  input  logic            rst_n,
  ps2_host_tx_if.slave    tx,
  input  logic            ps2_clk_in,
  input  logic            ps2_data_in,
  output logic            ps2_clk_oe,
  output logic            ps2_data_oe
);

  // One counter serves both the inhibit interval and the frame timeout
  localparam int unsigned CntMax = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES
                                                                     : INHIBIT_CYCLES;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  state_e          state_q, state_d;
  logic [7:0]      shift_q, shift_d;
  logic            parity_q, parity_d;
  logic [3:0]      bit_idx_q, bit_idx_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            data_q, data_d;
  logic            ack_q, ack_d;
  logic            done_q, done_d;
  logic            err_q, err_d;

  logic clk_s, clk_fall;
  logic data_s, data_fall;
  logic inhibit_last, timeout;

  ps2_line_sync u_clk_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .line  (ps2_clk_in),
    .sync  (clk_s),
    .fall  (clk_fall)
  );

  ps2_line_sync u_data_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .line  (ps2_data_in),
    .sync  (data_s),
    .fall  (data_fall)
  );

  assign inhibit_last = (cnt_q == CntW'(INHIBIT_CYCLES - 1));
  assign timeout      = (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      bit_idx_q <= '0;
      cnt_q     <= '0;
      data_q    <= 1'b0;
      ack_q     <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
      bit_idx_q <= bit_idx_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      ack_q     <= ack_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  // Next-state, bit sequencing and completion pulses
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    bit_idx_d = bit_idx_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    ack_d     = ack_q;
    done_d    = 1'b0;
    err_d     = 1'b0;

    unique case (state_q)
      StIdle: begin
        data_d = 1'b0;
        if (tx.tx_valid) begin
          shift_d   = tx.tx_data;
          parity_d  = odd_parity(tx.tx_data);
          cnt_d     = '0;
          bit_idx_d = '0;
          ack_d     = 1'b0;
          state_d   = StInhibit;
        end
      end

      StInhibit: begin
        if (inhibit_last) begin
          // Start bit (line low) is already driven when the clock is released
          cnt_d     = '0;
          bit_idx_d = '0;
          data_d    = 1'b1;
          state_d   = StSend;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      StSend: begin
        // Timeout takes priority over a coincident clock fall
        if (timeout) begin
          data_d  = 1'b0;
          err_d   = 1'b1;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + CntW'(1);
          if (clk_fall) begin
            if (bit_idx_q < 4'd8) begin
              data_d = ~shift_q[bit_idx_q[2:0]];
            end else if (bit_idx_q == 4'd8) begin
              data_d = ~parity_q;
            end else if (bit_idx_q == 4'd9) begin
              data_d = 1'b0;
            end else begin
              data_d  = 1'b0;
              ack_d   = data_s;
              state_d = StWaitRel;
            end
            if (bit_idx_q != 4'd10) begin
              bit_idx_d = bit_idx_q + 4'd1;
            end
          end
        end
      end

      StWaitRel: begin
        data_d = 1'b0;
        if (timeout) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + CntW'(1);
          if (clk_s && data_s) begin
            done_d  = ~ack_q;
            err_d   = ack_q;
            state_d = StIdle;
          end
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Line drives are decoded from state so reset releases them immediately
  assign ps2_clk_oe  = (state_q == StInhibit);
  assign ps2_data_oe = ((state_q == StInhibit) && inhibit_last) ||
                       ((state_q == StSend) && data_q);

  assign tx.tx_ready = (state_q == StIdle);
  assign tx.busy     = (state_q != StIdle);
  assign tx.tx_done  = done_q;
  assign tx.tx_err   = err_q;

  // Data-line falls are not needed by the transmitter
  logic unused_data_fall;
  assign unused_data_fall = data_fall;

endmodule
